// File: rtl/mul_ctrl_pkg.sv
// rtl/mul_ctrl_pkg.sv - shared state encoding and defaults for the shift-free multiply controller
// Purpose: state encoding and default WIDTH/MAX_ITER values shared by the
// controller, the iteration counter, the datapath top and the bench.
// Ports: none (package).
package mul_ctrl_pkg;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_MAX_ITER = 65535;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_CHECK  = 3'd3,
        S_ACC    = 3'd4,
        S_DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/mul_iter_cnt.sv
// rtl/mul_iter_cnt.sv - saturating accumulate-iteration counter
// Purpose: counts accumulate cycles; clear wins over increment and the count
// sticks at MAX_VAL instead of wrapping.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to zero
//   inc        : increment by one (ignored at MAX_VAL)
//   count      : current count
module mul_iter_cnt
    import mul_ctrl_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MAX_VAL = DEF_MAX_ITER
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MAX_VAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != LIMIT)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mul_controller.sv
// rtl/mul_controller.sv - FSM sequencing a repeated-add multiplier datapath
// Purpose: loads A then B from a shared bus, then alternates CHECK/ACC until
// the B counter reaches zero or the watchdog limit is hit.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   start, abort            : begin a multiply (IDLE only) / cancel it
//   data_valid, data_ready  : operand handshake on the shared data bus
//   eqz                     : datapath B counter is zero
//   ldA, ldB, ldP, clrP,
//   decB                    : datapath strobes
//   busy, done, error       : status; error qualifies done (watchdog)
//   iter                    : accumulate cycles in current/last operation
module mul_controller
    import mul_ctrl_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_ITER = DEF_MAX_ITER
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             data_valid,
    input  logic             eqz,
    output logic             data_ready,
    output logic             ldA,
    output logic             ldB,
    output logic             ldP,
    output logic             clrP,
    output logic             decB,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] iter
);

    state_t state_q;
    state_t state_d;
    logic   error_q;
    logic   error_d;
    logic   iter_clr;
    logic   iter_inc;
    logic   at_max;
    logic   kill;

    assign at_max = (iter == WIDTH'(MAX_ITER));
    // Abort only has effect once an operation is under way.
    assign kill   = abort && (state_q != S_IDLE);

    mul_iter_cnt #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_ITER)
    ) u_iter_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (iter_clr),
        .inc   (iter_inc),
        .count (iter)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        error_d = error_q;
        if (kill) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_LOAD_A;
                        error_d = 1'b0;
                    end
                end
                S_LOAD_A: begin
                    if (data_valid) state_d = S_LOAD_B;
                end
                S_LOAD_B: begin
                    if (data_valid) state_d = S_CHECK;
                end
                S_CHECK: begin
                    if (eqz) begin
                        state_d = S_DONE;
                        error_d = 1'b0;
                    end else if (at_max) begin
                        state_d = S_DONE;
                        error_d = 1'b1;
                    end else begin
                        state_d = S_ACC;
                    end
                end
                S_ACC:   state_d = S_CHECK;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Strobes are Mealy on data_valid and all gated by abort, so a cancelled
    // cycle never disturbs the datapath.
    always_comb begin
        data_ready = 1'b0;
        ldA        = 1'b0;
        ldB        = 1'b0;
        ldP        = 1'b0;
        clrP       = 1'b0;
        decB       = 1'b0;
        done       = 1'b0;
        iter_clr   = 1'b0;
        iter_inc   = 1'b0;
        busy       = (state_q != S_IDLE);
        error      = error_q;
        if (!kill) begin
            case (state_q)
                S_IDLE: iter_clr = start;
                S_LOAD_A: begin
                    data_ready = 1'b1;
                    ldA        = data_valid;
                end
                S_LOAD_B: begin
                    data_ready = 1'b1;
                    ldB        = data_valid;
                    clrP       = data_valid;
                end
                S_ACC: begin
                    ldP      = 1'b1;
                    decB     = 1'b1;
                    iter_inc = 1'b1;
                end
                S_DONE:  done = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
